// File: rtl/mode_counter_if.sv
// Control and status bundle for mode_counter.
// The master side owns the control inputs, and the slave side is the counter itself.
interface mode_counter_if #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
);

   // Control: enable, clear, load and run-time configuration
   logic                  en;
   logic                  clr;
   logic                  load;
   logic [WIDTH-1:0]      load_val;
   logic [WIDTH-1:0]      limit;
   logic [1:0]            mode;
   logic [PRESCALE_W-1:0] presc;

   // Status: all registered inside the counter
   logic [WIDTH-1:0]      count;
   logic                  dir;
   logic                  tc;
   logic                  done;

   // The block that drives configuration and consumes status
   modport master (
      output en,
      output clr,
      output load,
      output load_val,
      output limit,
      output mode,
      output presc,
      input  count,
      input  dir,
      input  tc,
      input  done
   );

   // The counter itself
   modport slave (
      input  en,
      input  clr,
      input  load,
      input  load_val,
      input  limit,
      input  mode,
      input  presc,
      output count,
      output dir,
      output tc,
      output done
   );

endinterface

// File: rtl/mode_counter.sv
// Parametrised timebase counter.
// It supports four counting modes, a prescaled clock enable and synchronous clear/load.
// It also provides a registered terminal-count pulse and a sticky one-shot done flag.
// Update priority on every edge is: rst > clr > load > prescaled tick.
module mode_counter #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   mode_counter_if.slave  bus
);

   typedef enum logic [1:0] {
      MODE_UP_WRAP   = 2'b00,
      MODE_DOWN_WRAP = 2'b01,
      MODE_BOUNCE    = 2'b10,
      MODE_ONE_SHOT  = 2'b11
   } mode_e;

   mode_e                 mode;

   logic [WIDTH-1:0]      count_q, count_d;
   logic                  dir_q, dir_d;
   logic                  tc_q, tc_d;
   logic                  done_q, done_d;
   logic [PRESCALE_W-1:0] pc_q, pc_d;

   // Prescaler results when neither clr nor load is active
   logic                  tick;
   logic [PRESCALE_W-1:0] pc_run;

   // Load path: clamped value and the direction that goes with it
   logic [WIDTH-1:0]      load_clamped;
   logic                  load_dir;

   // Tick path: candidate next state for one counting step
   logic [WIDTH-1:0]      step_count;
   logic                  step_dir;
   logic                  step_tc;
   logic                  step_done;
   logic [WIDTH-1:0]      count_inc;
   logic [WIDTH-1:0]      count_dec;

   assign mode      = mode_e'(bus.mode);
   assign count_inc = count_q + WIDTH'(1);
   assign count_dec = count_q - WIDTH'(1);

   // Prescaler: a tick fires when an enabled cycle finds pc equal to the divisor.
   // If presc was lowered below pc, pc keeps counting and wraps before it matches.
   always_comb begin
      tick   = 1'b0;
      pc_run = pc_q;
      if (bus.en) begin
         if (pc_q == bus.presc) begin
            tick   = 1'b1;
            pc_run = '0;
         end else begin
            pc_run = pc_q + PRESCALE_W'(1);
         end
      end
   end

   // Load: clamp to limit and pick the starting direction for the current mode
   always_comb begin
      load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      load_dir     = 1'b1;
      case (mode)
         MODE_DOWN_WRAP: load_dir = 1'b0;
         // Loading the top of a bounce ramp starts it heading down
         MODE_BOUNCE:    load_dir = !((load_clamped == bus.limit) && (bus.limit != '0));
         default:        load_dir = 1'b1;
      endcase
   end

   // One counting step per mode, used only on a tick
   always_comb begin
      step_count = count_q;
      step_dir   = dir_q;
      step_tc    = 1'b0;
      step_done  = done_q;
      case (mode)
         MODE_UP_WRAP: begin
            step_dir = 1'b1;
            // >= also recovers a count that sits above a freshly lowered limit
            if (count_q >= bus.limit) begin
               step_count = '0;
               step_tc    = 1'b1;
            end else begin
               step_count = count_inc;
            end
         end
         MODE_DOWN_WRAP: begin
            step_dir = 1'b0;
            // A count above limit simply walks down until it reaches zero
            if (count_q == '0) begin
               step_count = bus.limit;
               step_tc    = 1'b1;
            end else begin
               step_count = count_dec;
            end
         end
         MODE_BOUNCE: begin
            if (bus.limit == '0) begin
               // A degenerate ramp pins at zero and reports every tick
               step_count = '0;
               step_dir   = 1'b1;
               step_tc    = 1'b1;
            end else if (dir_q) begin
               if (count_q >= bus.limit) begin
                  step_count = bus.limit - WIDTH'(1);
                  step_dir   = 1'b0;
                  step_tc    = 1'b1;
               end else begin
                  step_count = count_inc;
               end
            end else begin
               if (count_q == '0) begin
                  step_count = WIDTH'(1);
                  step_dir   = 1'b1;
                  step_tc    = 1'b1;
               end else begin
                  step_count = count_dec;
               end
            end
         end
         MODE_ONE_SHOT: begin
            step_dir = 1'b1;
            // count_inc only wraps at all-ones, where count >= limit already holds
            if (!done_q) begin
               if ((count_q >= bus.limit) || (count_inc >= bus.limit)) begin
                  step_count = bus.limit;
                  step_done  = 1'b1;
                  step_tc    = 1'b1;
               end else begin
                  step_count = count_inc;
               end
            end
         end
         default: begin
            step_count = count_q;
         end
      endcase
   end

   // Next-state selection: clr beats load, and load beats and discards a same-cycle tick
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      pc_d    = pc_q;
      if (bus.clr) begin
         count_d = '0;
         pc_d    = '0;
         done_d  = 1'b0;
         dir_d   = (mode != MODE_DOWN_WRAP);
      end else if (bus.load) begin
         count_d = load_clamped;
         pc_d    = '0;
         done_d  = 1'b0;
         dir_d   = load_dir;
      end else begin
         pc_d = pc_run;
         if (tick) begin
            count_d = step_count;
            dir_d   = step_dir;
            tc_d    = step_tc;
            done_d  = step_done;
         end
      end
   end

   // State register with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         dir_q   <= 1'b1;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         pc_q    <= '0;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.count = count_q;
   assign bus.dir   = dir_q;
   assign bus.tc    = tc_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter.
// It holds a table of per-cycle {inputs, expected outputs} records grouped in scenario blocks.
// Expected outputs go through a queue that is filled at drive time and drained at sample time.
// Hand-written sequences cover asynchronous reset.
module tb_mode_counter;

   localparam int W  = 8;
   localparam int PW = 4;

   localparam logic [1:0] M_UP = 2'd0;
   localparam logic [1:0] M_DN = 2'd1;
   localparam logic [1:0] M_BN = 2'd2;
   localparam logic [1:0] M_OS = 2'd3;

   typedef struct {
      logic          en;
      logic          clr;
      logic          load;
      logic [W-1:0]  load_val;
      logic [W-1:0]  limit;
      logic [1:0]    mode;
      logic [PW-1:0] presc;
      logic [W-1:0]  e_count;
      logic          e_dir;
      logic          e_tc;
      logic          e_done;
   } vec_t;

   vec_t         vecs[$];
   logic [W+2:0] exp_q[$];
   int           tests_run    = 0;
   int           tests_failed = 0;

   // Expected count sequences for the scenario blocks
   int a_cnt [13] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
   int b_cnt [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
   int b_dir [8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
   int b_tc  [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
   int c_cnt [7]  = '{4, 3, 2, 1, 0, 5, 4};
   int c2_cnt[6]  = '{3, 2, 1, 0, 2, 1};

   // Clock and reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mode_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

   mode_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W+2:0] pack(logic [W-1:0] c, logic d, logic t, logic dn);
      return {c, d, t, dn};
   endfunction

   function automatic void check(string name, int idx, logic [W+2:0] act, logic [W+2:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s[%0d]: got count=%0d dir=%0b tc=%0b done=%0b, want count=%0d dir=%0b tc=%0b done=%0b",
                  name, idx, act[W+2:3], act[2], act[1], act[0],
                  exp[W+2:3], exp[2], exp[1], exp[0]);
      end
   endfunction

   function automatic void add_vec(logic en, logic clr, logic load, logic [W-1:0] lv,
                                   logic [W-1:0] lim, logic [1:0] mode, logic [PW-1:0] presc,
                                   logic [W-1:0] c, logic d, logic t, logic dn);
      vec_t v;
      v.en = en; v.clr = clr; v.load = load; v.load_val = lv; v.limit = lim;
      v.mode = mode; v.presc = presc;
      v.e_count = c; v.e_dir = d; v.e_tc = t; v.e_done = dn;
      vecs.push_back(v);
   endfunction

   function automatic void tick_vec(logic [W-1:0] lim, logic [1:0] mode, logic [PW-1:0] presc,
                                    logic [W-1:0] c, logic d, logic t, logic dn);
      add_vec(1'b1, 1'b0, 1'b0, '0, lim, mode, presc, c, d, t, dn);
   endfunction

   // Driver: apply one record at the falling edge
   task automatic drive(input vec_t v);
      bus.en       = v.en;
      bus.clr      = v.clr;
      bus.load     = v.load;
      bus.load_val = v.load_val;
      bus.limit    = v.limit;
      bus.mode     = v.mode;
      bus.presc    = v.presc;
   endtask

   // Apply all queued records, one clock each, and compare 1 ns after the rising edge
   task automatic apply_all(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         exp_q.push_back(pack(vecs[i].e_count, vecs[i].e_dir, vecs[i].e_tc, vecs[i].e_done));
         @(posedge clk);
         #1;
         check(tag, i, pack(bus.count, bus.dir, bus.tc, bus.done), exp_q.pop_front());
      end
      vecs.delete();
   endtask

   initial begin
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.limit    = '0;
      bus.mode     = M_UP;
      bus.presc    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 0, pack(bus.count, bus.dir, bus.tc, bus.done), pack(8'd0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;

      // Prescaler: limit 3, presc 2, then en low for 5 cycles freezes count and pc
      for (int i = 0; i < 13; i++)
         tick_vec(3, M_UP, 2, W'(a_cnt[i]), 1'b1, (i == 11), 1'b0);
      for (int i = 0; i < 5; i++)
         add_vec(1'b0, 1'b0, 1'b0, '0, 3, M_UP, 2, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(3, M_UP, 2, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(3, M_UP, 2, 1, 1'b1, 1'b0, 1'b0);
      apply_all("presc");

      // Bounce: limit 3, presc 0
      add_vec(1'b1, 1'b1, 1'b0, '0, 3, M_BN, 0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
         tick_vec(3, M_BN, 0, W'(b_cnt[i]), b_dir[i] != 0, b_tc[i] != 0, 1'b0);
      apply_all("bounce");

      // Down-wrap: load above limit clamps, then a limit change at run time
      add_vec(1'b1, 1'b0, 1'b1, 9, 5, M_DN, 0, 5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         tick_vec(5, M_DN, 0, W'(c_cnt[i]), 1'b0, (i == 5), 1'b0);
      for (int i = 0; i < 6; i++)
         tick_vec(2, M_DN, 0, W'(c2_cnt[i]), 1'b0, (i == 4), 1'b0);
      apply_all("down");

      // One-shot: limit 4, hold after done, reload restarts, then the limit-0 case
      add_vec(1'b1, 1'b1, 1'b0, '0, 4, M_OS, 0, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 1, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 2, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 3, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 4, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         tick_vec(4, M_OS, 0, 4, 1'b1, 1'b0, 1'b1);
      add_vec(1'b1, 1'b0, 1'b1, 1, 4, M_OS, 0, 1, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 2, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 3, 1'b1, 1'b0, 1'b0);
      tick_vec(4, M_OS, 0, 4, 1'b1, 1'b1, 1'b1);
      tick_vec(4, M_OS, 0, 4, 1'b1, 1'b0, 1'b1);
      add_vec(1'b1, 1'b1, 1'b0, '0, 0, M_OS, 0, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(0, M_OS, 0, 0, 1'b1, 1'b1, 1'b1);
      tick_vec(0, M_OS, 0, 0, 1'b1, 1'b0, 1'b1);
      apply_all("oneshot");

      // Limit 0 edge cases: bounce pins at 0 and pulses tc; down clr sets dir 0
      add_vec(1'b1, 1'b1, 1'b0, '0, 0, M_BN, 0, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(0, M_BN, 0, 0, 1'b1, 1'b1, 1'b0);
      tick_vec(0, M_BN, 0, 0, 1'b1, 1'b1, 1'b0);
      add_vec(1'b1, 1'b1, 1'b0, '0, 5, M_DN, 0, 0, 1'b0, 1'b0, 1'b0);
      tick_vec(5, M_DN, 0, 5, 1'b0, 1'b1, 1'b0);
      tick_vec(5, M_DN, 0, 4, 1'b0, 1'b0, 1'b0);
      apply_all("edge");

      // Priority: clr+load on a tick cycle, then load alone on a tick cycle (presc 2)
      add_vec(1'b1, 1'b0, 1'b1, 7, 20, M_UP, 2, 7, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 7, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 7, 1'b1, 1'b0, 1'b0);
      add_vec(1'b1, 1'b1, 1'b1, 9, 20, M_UP, 2, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 0, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 1, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 1, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 1, 1'b1, 1'b0, 1'b0);
      add_vec(1'b1, 1'b0, 1'b1, 10, 20, M_UP, 2, 10, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 10, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 10, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_UP, 2, 11, 1'b1, 1'b0, 1'b0);
      apply_all("priority");

      // Load direction and clamping across modes
      add_vec(1'b0, 1'b0, 1'b1, 50, 20, M_UP, 0, 20, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 50, 20, M_BN, 0, 20, 1'b0, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 5, 20, M_BN, 0, 5, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 3, 0, M_BN, 0, 0, 1'b1, 1'b0, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 3, 20, M_DN, 0, 3, 1'b0, 1'b0, 1'b0);
      // Mode changes keep count; bounce takes dir as it stands
      tick_vec(20, M_UP, 0, 4, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_BN, 0, 5, 1'b1, 1'b0, 1'b0);
      tick_vec(20, M_DN, 0, 4, 1'b0, 1'b0, 1'b0);
      tick_vec(20, M_BN, 0, 3, 1'b0, 1'b0, 1'b0);
      apply_all("load_mode");

      // Full 8-bit up-wrap with limit 255
      add_vec(1'b1, 1'b1, 1'b0, '0, 255, M_UP, 0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 256; i++)
         tick_vec(255, M_UP, 0, W'(i % 256), 1'b1, (i == 256), 1'b0);
      for (int i = 1; i <= 100; i++)
         tick_vec(255, M_UP, 0, W'(i), 1'b1, 1'b0, 1'b0);
      apply_all("wrap255");

      // Asynchronous reset at count 100: outputs clear before any clock edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst", 0, pack(bus.count, bus.dir, bus.tc, bus.done), pack(8'd0, 1'b1, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      check("rst_hold", 0, pack(bus.count, bus.dir, bus.tc, bus.done), pack(8'd0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_resume", 0, pack(bus.count, bus.dir, bus.tc, bus.done), pack(8'd1, 1'b1, 1'b0, 1'b0));

      // rst also clears a sticky done
      tick_vec(0, M_OS, 0, 0, 1'b1, 1'b1, 1'b1);
      apply_all("done_set");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_done", 0, pack(bus.count, bus.dir, bus.tc, bus.done), pack(8'd0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;

      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
